// File: rtl/blinker_pkg.sv
// Shared types, control-bit indices and seven-segment codes
// for the LED/seven-segment blinker engine.
package blinker_pkg;

   typedef enum logic [1:0] {
      M_OFF    = 2'b00,
      M_BLINK  = 2'b01,
      M_SHIFT  = 2'b10,
      M_BOUNCE = 2'b11
   } mode_e;

   localparam int SW_MODE_LO = 0;
   localparam int SW_MODE_HI = 1;
   localparam int SW_PAUSE   = 2;
   localparam int SW_FAST    = 3;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // dp (bit 7) is always returned dark; callers light it
   function automatic logic [7:0] bcd_to_seg7(
      input logic [3:0] bcd
   );
      case (bcd)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/led_seg_blinker_debounce.sv
// One-bit switch debouncer: 2-FF synchroniser followed by
// a stability counter that must run out before the level is taken.
module sw_debounce
   import blinker_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_async,
   output logic sw_db
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // a sample equal to the accepted level restarts the count
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         sw_db <= 1'b0;
      end else begin
         s1 <= sw_async;
         s2 <= s1;
         if (s2 == sw_db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            sw_db <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_seg_blinker.sv
// Blinker engine: debounced switches select an LED pattern mode,
// a prescaler paces it, and a BCD tick counter drives the displays.
module led_seg_blinker
   import blinker_pkg::*;
#(
   parameter int NUM_LEDS        = 8,
   parameter int NUM_DIGITS      = 4,
   parameter int NUM_SW          = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_DIV        = 5000000
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset,
   input  logic [NUM_SW-1:0]       switcher_export,
   output logic [NUM_LEDS-1:0]     led_export,
   output logic [NUM_DIGITS*8-1:0] seven_seg_export
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LIM_N = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] LIM_F = PW'(TICK_DIV / 2 - 1);

   logic [NUM_SW-1:0] sw_db;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_db
      sw_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk     (clk_clk),
         .rst     (reset_reset),
         .sw_async(switcher_export[i]),
         .sw_db   (sw_db[i])
      );
   end

   mode_e   state;
   mode_e   mode_req;
   logic    pause;
   logic    fast;
   logic    fast_r;
   logic    dir_up;
   logic    tick;
   logic    mode_chg;
   logic [PW-1:0] pre;

   assign mode_req = mode_e'(sw_db[SW_MODE_HI:SW_MODE_LO]);
   assign pause    = sw_db[SW_PAUSE];
   assign fast     = sw_db[SW_FAST];
   assign mode_chg = (mode_req != state);

   // fast_r only moves at a wrap, so the limit never jumps below pre
   assign tick = !pause && (pre == (fast_r ? LIM_F : LIM_N));

   logic [3:0] digit     [NUM_DIGITS];
   logic [3:0] digit_nxt [NUM_DIGITS];
   logic       carry;

   always_comb begin
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digit_nxt[i] = digit[i];
         if (carry) begin
            if (digit[i] == 4'd9) begin
               digit_nxt[i] = 4'd0;
            end else begin
               digit_nxt[i] = digit[i] + 4'd1;
               carry        = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state      <= M_OFF;
         led_export <= '0;
         dir_up     <= 1'b1;
         pre        <= '0;
         fast_r     <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit[i] <= 4'd0;
         end
      end else if (mode_chg) begin
         state  <= mode_req;
         pre    <= '0;
         dir_up <= 1'b1;
         if (mode_req == M_SHIFT || mode_req == M_BOUNCE) begin
            led_export <= NUM_LEDS'(1);
         end else begin
            led_export <= '0;
         end
      end else if (tick) begin
         pre    <= '0;
         fast_r <= fast;
         unique case (state)
            M_OFF: begin
               led_export <= '0;
            end
            M_BLINK: begin
               led_export <= ~led_export;
            end
            M_SHIFT: begin
               led_export <= {led_export[NUM_LEDS-2:0],
                              led_export[NUM_LEDS-1]};
            end
            M_BOUNCE: begin
               if (dir_up) begin
                  if (led_export[NUM_LEDS-1]) begin
                     led_export <= led_export >> 1;
                     dir_up     <= 1'b0;
                  end else begin
                     led_export <= led_export << 1;
                  end
               end else begin
                  if (led_export[0]) begin
                     led_export <= led_export << 1;
                     dir_up     <= 1'b1;
                  end else begin
                     led_export <= led_export >> 1;
                  end
               end
            end
         endcase
         if (state != M_OFF) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               digit[i] <= digit_nxt[i];
            end
         end
      end else if (!pause) begin
         pre <= pre + 1'b1;
      end
   end

   logic [NUM_DIGITS*8-1:0] seg_nxt;

   always_comb begin
      seg_nxt = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         seg_nxt[8*i +: 8] = bcd_to_seg7(digit[i]);
      end
      seg_nxt[7] = ~pause;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            seven_seg_export[8*i +: 8] <= SEG_0;
         end
      end else begin
         seven_seg_export <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_led_seg_blinker.sv
// Directed bench for led_seg_blinker with short debounce and tick
// periods; expected LED and segment values are hand-derived.
module tb_led_seg_blinker;

   logic        clk;
   logic        reset;
   logic [3:0]  sw;
   logic [7:0]  led;
   logic [15:0] seg;

   int checks   = 0;
   int failures = 0;

   logic [7:0] bexp [14] = '{
      8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
      8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
   };

   led_seg_blinker #(
      .NUM_LEDS       (8),
      .NUM_DIGITS     (2),
      .NUM_SW         (4),
      .DEBOUNCE_CYCLES(4),
      .TICK_DIV       (8)
   ) dut (
      .clk_clk         (clk),
      .reset_reset     (reset),
      .switcher_export (sw),
      .led_export      (led),
      .seven_seg_export(seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      sw    = 4'hF;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         checks++;
         if (led !== 8'h00 || seg !== 16'hC0C0) begin
            failures++;
            $display("FAIL reset_hold led=%h seg=%h exp 00/C0C0", led, seg);
         end
      end
      reset = 1'b0;
      sw    = 4'h0;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         checks++;
         if (led !== 8'h00 || seg !== 16'hC0C0) begin
            failures++;
            $display("FAIL reset_after led=%h seg=%h exp 00/C0C0", led, seg);
         end
      end
   endtask

   task automatic test_debounce();
      sw = 4'b0010;
      cyc(3);
      sw = 4'b0000;
      cyc(10);
      checks++;
      if (led !== 8'h00 || seg !== 16'hC0C0) begin
         failures++;
         $display("FAIL bounce_reject led=%h seg=%h exp 00/C0C0", led, seg);
      end
      sw = 4'b0010;
      cyc(6);
      checks++;
      if (led !== 8'h00) begin
         failures++;
         $display("FAIL shift_early led=%h exp 00", led);
      end
      cyc(1);
      checks++;
      if (led !== 8'h01) begin
         failures++;
         $display("FAIL shift_entry led=%h exp 01", led);
      end
   endtask

   task automatic test_shift();
      logic [7:0] exp;
      cyc(7);
      checks++;
      if (led !== 8'h01) begin
         failures++;
         $display("FAIL shift_wait led=%h exp 01", led);
      end
      exp = 8'h02;
      cyc(1);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) cyc(8);
         checks++;
         if (led !== exp) begin
            failures++;
            $display("FAIL shift_step%0d led=%h exp %h", i, led, exp);
         end
         exp = {exp[6:0], exp[7]};
      end
      cyc(1);
      checks++;
      if (seg !== 16'hC080) begin
         failures++;
         $display("FAIL shift_count seg=%h exp C080", seg);
      end
      sw = 4'b1010;
      cyc(7);
      checks++;
      if (led !== 8'h02) begin
         failures++;
         $display("FAIL fast_wrap led=%h exp 02", led);
      end
      cyc(3);
      checks++;
      if (led !== 8'h02) begin
         failures++;
         $display("FAIL fast_hold led=%h exp 02", led);
      end
      cyc(1);
      checks++;
      if (led !== 8'h04) begin
         failures++;
         $display("FAIL fast_tick1 led=%h exp 04", led);
      end
      cyc(4);
      checks++;
      if (led !== 8'h08) begin
         failures++;
         $display("FAIL fast_tick2 led=%h exp 08", led);
      end
      sw = 4'b1110;
      cyc(20);
      checks++;
      if (led !== 8'h10 || seg !== 16'hF924) begin
         failures++;
         $display("FAIL pause led=%h seg=%h exp 10/F924", led, seg);
      end
   endtask

   task automatic test_bounce();
      reset = 1'b1;
      sw    = 4'b0011;
      cyc(2);
      reset = 1'b0;
      cyc(6);
      checks++;
      if (led !== 8'h00) begin
         failures++;
         $display("FAIL bounce_early led=%h exp 00", led);
      end
      cyc(1);
      checks++;
      if (led !== 8'h01) begin
         failures++;
         $display("FAIL bounce_entry led=%h exp 01", led);
      end
      for (int i = 0; i < 14; i++) begin
         cyc(8);
         checks++;
         if (led !== bexp[i]) begin
            failures++;
            $display("FAIL bounce_step%0d led=%h exp %h", i, led, bexp[i]);
         end
      end
      cyc(1);
      checks++;
      if (seg !== 16'hF999) begin
         failures++;
         $display("FAIL bounce_count seg=%h exp F999", seg);
      end
      cyc(7);
      checks++;
      if (led !== 8'h02) begin
         failures++;
         $display("FAIL bounce_period led=%h exp 02", led);
      end
   endtask

   task automatic test_bcd_wrap();
      logic [7:0] exp;
      reset = 1'b1;
      sw    = 4'b1001;
      cyc(2);
      reset = 1'b0;
      cyc(7);
      checks++;
      if (led !== 8'h00) begin
         failures++;
         $display("FAIL blink_entry led=%h exp 00", led);
      end
      cyc(8);
      checks++;
      if (led !== 8'hFF) begin
         failures++;
         $display("FAIL blink_tick1 led=%h exp FF", led);
      end
      exp = 8'h00;
      for (int k = 2; k <= 99; k++) begin
         cyc(4);
         checks++;
         if (led !== exp) begin
            failures++;
            $display("FAIL blink_tick%0d led=%h exp %h", k, led, exp);
         end
         exp = ~exp;
      end
      cyc(1);
      checks++;
      if (seg !== 16'h9090) begin
         failures++;
         $display("FAIL bcd_99 seg=%h exp 9090", seg);
      end
      cyc(3);
      checks++;
      if (led !== 8'h00) begin
         failures++;
         $display("FAIL blink_tick100 led=%h exp 00", led);
      end
      cyc(1);
      checks++;
      if (seg !== 16'hC0C0) begin
         failures++;
         $display("FAIL bcd_wrap seg=%h exp C0C0", seg);
      end
   endtask

   task automatic test_corners();
      reset = 1'b1;
      sw    = 4'b0010;
      cyc(2);
      reset = 1'b0;
      cyc(7);
      checks++;
      if (led !== 8'h01) begin
         failures++;
         $display("FAIL corner_entry led=%h exp 01", led);
      end
      cyc(1);
      sw = 4'b0011;
      cyc(6);
      checks++;
      if (led !== 8'h01) begin
         failures++;
         $display("FAIL corner_pre led=%h exp 01", led);
      end
      cyc(1);
      checks++;
      if (led !== 8'h01) begin
         failures++;
         $display("FAIL corner_drop led=%h exp 01", led);
      end
      cyc(7);
      checks++;
      if (led !== 8'h01) begin
         failures++;
         $display("FAIL corner_clear led=%h exp 01", led);
      end
      cyc(1);
      checks++;
      if (led !== 8'h02) begin
         failures++;
         $display("FAIL corner_tick led=%h exp 02", led);
      end
      cyc(1);
      checks++;
      if (seg !== 16'hC0F9) begin
         failures++;
         $display("FAIL corner_count seg=%h exp C0F9", seg);
      end
      reset = 1'b1;
      cyc(1);
      checks++;
      if (led !== 8'h00 || seg !== 16'hC0C0) begin
         failures++;
         $display("FAIL mid_reset led=%h seg=%h exp 00/C0C0", led, seg);
      end
      sw = 4'b0000;
      cyc(1);
      reset = 1'b0;
      cyc(10);
      checks++;
      if (led !== 8'h00 || seg !== 16'hC0C0) begin
         failures++;
         $display("FAIL post_reset led=%h seg=%h exp 00/C0C0", led, seg);
      end
   endtask

   initial begin
      reset = 1'b1;
      sw    = 4'h0;
      test_reset();
      test_debounce();
      test_shift();
      test_bounce();
      test_bcd_wrap();
      test_corners();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
